// File: rtl/dcache_ctrl_pkg.sv
// Shared constants, state encoding and helpers for the data cache controller.
package dcache_ctrl_pkg;

  localparam int OFFSET_W  = 5;
  localparam int INDEX_W   = 4;
  localparam int TAG_W     = 23;
  localparam int LINE_W    = 256;
  localparam int NUM_LINES = 1 << INDEX_W;
  localparam int WORD_W    = 32;
  localparam int WSEL_W    = OFFSET_W - 2;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_WRITEBACK   = 2'd1,
    ST_REFILL      = 2'd2,
    ST_REFILL_DONE = 2'd3
  } state_e;

  // Rebuild a line-aligned byte address from its tag and index.
  function automatic logic [31:0] line_addr(input logic [TAG_W-1:0] tag,
                                            input logic [INDEX_W-1:0] idx);
    return {tag, idx, {OFFSET_W{1'b0}}};
  endfunction

endpackage

// File: rtl/dcache_sram.sv
// Tag/valid/dirty/data storage: combinational read, synchronous write.
// A full-line refill takes priority over a word store to the same line.
module dcache_sram
  import dcache_ctrl_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [INDEX_W-1:0] idx_i,
  output logic               rd_valid_o,
  output logic               rd_dirty_o,
  output logic [TAG_W-1:0]   rd_tag_o,
  output logic [LINE_W-1:0]  rd_line_o,
  input  logic               word_we_i,
  input  logic [WSEL_W-1:0]  word_sel_i,
  input  logic [WORD_W-1:0]  word_data_i,
  input  logic               line_we_i,
  input  logic [TAG_W-1:0]   line_tag_i,
  input  logic [LINE_W-1:0]  line_data_i
);

  logic [LINE_W-1:0]    data_mem [NUM_LINES];
  logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
  logic [NUM_LINES-1:0] valid_reg;
  logic [NUM_LINES-1:0] dirty_reg;

  assign rd_valid_o = valid_reg[idx_i];
  assign rd_dirty_o = dirty_reg[idx_i];
  assign rd_tag_o   = tag_mem[idx_i];
  assign rd_line_o  = data_mem[idx_i];

  // Line payload and tag: refill writes the whole line, a store one word.
  always_ff @(posedge clk_i) begin
    if (line_we_i) begin
      data_mem[idx_i] <= line_data_i;
      tag_mem[idx_i]  <= line_tag_i;
    end else if (word_we_i) begin
      data_mem[idx_i][word_sel_i*WORD_W +: WORD_W] <= word_data_i;
    end
  end

  // Per-line status bits; only these are cleared by reset.
  generate
    for (genvar gi = 0; gi < NUM_LINES; gi++) begin : g_status
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          valid_reg[gi] <= 1'b0;
          dirty_reg[gi] <= 1'b0;
        end else if (idx_i == INDEX_W'(gi)) begin
          if (line_we_i) begin
            valid_reg[gi] <= 1'b1;
            dirty_reg[gi] <= 1'b0;
          end else if (word_we_i) begin
            dirty_reg[gi] <= 1'b1;
          end
        end
      end
    end
  endgenerate

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back write-allocate data cache controller (MEM stage).
// The pipeline holds cpu_* stable while stalled, so nothing is latched here.
module dcache_ctrl
  import dcache_ctrl_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [31:0]       cpu_addr_i,
  input  logic [31:0]       cpu_data_i,
  output logic [31:0]       cpu_data_o,
  output logic              cpu_stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [31:0]       mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i
);

  state_e state_reg, state_next;

  logic [TAG_W-1:0]   cpu_tag;
  logic [INDEX_W-1:0] cpu_idx;
  logic [WSEL_W-1:0]  cpu_wsel;
  logic               unused_addr_bits;

  logic               rd_valid, rd_dirty, hit;
  logic [TAG_W-1:0]   rd_tag;
  logic [LINE_W-1:0]  rd_line;
  logic               word_we, line_we;

  assign cpu_tag          = cpu_addr_i[31:OFFSET_W+INDEX_W];
  assign cpu_idx          = cpu_addr_i[OFFSET_W+INDEX_W-1:OFFSET_W];
  assign cpu_wsel         = cpu_addr_i[OFFSET_W-1:2];
  assign unused_addr_bits = ^cpu_addr_i[1:0];

  assign hit = cpu_req_i & rd_valid & (rd_tag == cpu_tag);

  dcache_sram u_sram (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .idx_i       (cpu_idx),
    .rd_valid_o  (rd_valid),
    .rd_dirty_o  (rd_dirty),
    .rd_tag_o    (rd_tag),
    .rd_line_o   (rd_line),
    .word_we_i   (word_we),
    .word_sel_i  (cpu_wsel),
    .word_data_i (cpu_data_i),
    .line_we_i   (line_we),
    .line_tag_i  (cpu_tag),
    .line_data_i (mem_data_i)
  );

  // State register; reset abandons any outstanding memory transaction.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  // Next-state, stall, memory handshake and CPU read data.
  always_comb begin
    state_next  = state_reg;
    cpu_data_o  = '0;
    cpu_stall_o = 1'b1;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_data_o  = '0;
    word_we     = 1'b0;
    line_we     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        cpu_stall_o = 1'b0;
        if (cpu_req_i) begin
          if (hit) begin
            if (cpu_we_i) word_we    = 1'b1;
            else          cpu_data_o = rd_line[cpu_wsel*WORD_W +: WORD_W];
          end else begin
            cpu_stall_o = 1'b1;
            state_next  = (rd_valid && rd_dirty) ? ST_WRITEBACK : ST_REFILL;
          end
        end
      end
      ST_WRITEBACK: begin
        mem_req_o  = 1'b1;
        mem_we_o   = 1'b1;
        mem_addr_o = line_addr(rd_tag, cpu_idx);
        mem_data_o = rd_line;
        if (mem_ack_i) state_next = ST_REFILL;
      end
      ST_REFILL: begin
        mem_req_o  = 1'b1;
        mem_addr_o = line_addr(cpu_tag, cpu_idx);
        if (mem_ack_i) begin
          line_we    = 1'b1;
          state_next = ST_REFILL_DONE;
        end
      end
      ST_REFILL_DONE: begin
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl with a hand-driven memory responder.
module tb_dcache_ctrl;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b0;
  logic         cpu_req_i = 1'b0;
  logic         cpu_we_i = 1'b0;
  logic [31:0]  cpu_addr_i = '0;
  logic [31:0]  cpu_data_i = '0;
  logic [31:0]  cpu_data_o;
  logic         cpu_stall_o;
  logic         mem_req_o;
  logic         mem_we_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic [255:0] mem_data_i = '0;
  logic         mem_ack_i = 1'b0;

  int total = 0;
  int bad   = 0;

  logic [255:0] line_a, line_b, line_c, line_d, exp_line;

  dcache_ctrl dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .cpu_req_i   (cpu_req_i),
    .cpu_we_i    (cpu_we_i),
    .cpu_addr_i  (cpu_addr_i),
    .cpu_data_i  (cpu_data_i),
    .cpu_data_o  (cpu_data_o),
    .cpu_stall_o (cpu_stall_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_data_o  (mem_data_o),
    .mem_data_i  (mem_data_i),
    .mem_ack_i   (mem_ack_i)
  );

  always #5 clk_i = ~clk_i;

  // Advance past the next rising edge, then let inputs be changed.
  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one miss from the IDLE cycle where it is presented until it is
  // back in IDLE, acting as memory and counting stall cycles on the way.
  task automatic miss(input string tag, input bit exp_wb, input int wb_lat,
                      input logic [31:0] wb_addr, input logic [255:0] wb_line,
                      input int rf_lat, input logic [31:0] rf_addr,
                      input logic [255:0] rf_line);
    int stalls;
    stalls = 0;
    #1;
    chk({tag, "_stall_now"}, cpu_stall_o, 1);
    chk({tag, "_req_idle"}, mem_req_o, 0);
    stalls += int'(cpu_stall_o);
    tick();
    if (exp_wb) begin
      chk({tag, "_wb_req"}, mem_req_o, 1);
      chk({tag, "_wb_we"}, mem_we_o, 1);
      chk({tag, "_wb_addr"}, mem_addr_o, wb_addr);
      chk({tag, "_wb_data"}, mem_data_o, wb_line);
      for (int i = 1; i < wb_lat; i++) begin
        stalls += int'(cpu_stall_o);
        tick();
        chk({tag, "_wb_hold"}, {mem_req_o, mem_we_o, mem_addr_o}, {2'b11, wb_addr});
      end
      mem_ack_i = 1'b1;
      #1;
      stalls += int'(cpu_stall_o);
      tick();
      mem_ack_i = 1'b0;
    end
    chk({tag, "_rf_req"}, mem_req_o, 1);
    chk({tag, "_rf_we"}, mem_we_o, 0);
    chk({tag, "_rf_addr"}, mem_addr_o, rf_addr);
    for (int i = 1; i < rf_lat; i++) begin
      stalls += int'(cpu_stall_o);
      tick();
      chk({tag, "_rf_hold"}, {mem_req_o, mem_addr_o}, {1'b1, rf_addr});
    end
    mem_ack_i  = 1'b1;
    mem_data_i = rf_line;
    #1;
    stalls += int'(cpu_stall_o);
    tick();
    mem_ack_i  = 1'b0;
    mem_data_i = '0;
    #1;
    chk({tag, "_done_req"}, mem_req_o, 0);
    chk({tag, "_done_stall"}, cpu_stall_o, 1);
    stalls += int'(cpu_stall_o);
    tick();
    #1;
    chk({tag, "_idle_stall"}, cpu_stall_o, 0);
    chk({tag, "_stall_cycles"}, 256'(stalls), 256'(2 + rf_lat + (exp_wb ? wb_lat : 0)));
    $display("miss %s addr=%h stall_cycles=%0d", tag, cpu_addr_i, stalls);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      line_a[i*32 +: 32] = 32'hA000_0000 + 32'(i);
      line_b[i*32 +: 32] = 32'hB000_0000 + 32'(i);
      line_c[i*32 +: 32] = 32'hC000_0000 + 32'(i);
      line_d[i*32 +: 32] = 32'hD000_0000 + 32'(i);
    end
    line_a[31:0] = 32'hDEADBEEF;

    // Reset
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
    #1;
    chk("rst_req", mem_req_o, 0);
    chk("rst_we", mem_we_o, 0);
    chk("rst_addr", mem_addr_o, 0);
    chk("rst_mdata", mem_data_o, 0);
    chk("rst_stall", cpu_stall_o, 0);
    chk("rst_cdata", cpu_data_o, 0);
    $display("reset released");

    // Cold load miss at 0x40, memory latency 10
    cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h40;
    miss("ld40", 0, 0, 0, 0, 10, 32'h40, line_a);
    chk("ld40_data", cpu_data_o, 32'hDEADBEEF);

    // Read hit on the neighbouring word
    cpu_addr_i = 32'h44;
    #1;
    chk("ld44_stall", cpu_stall_o, 0);
    chk("ld44_data", cpu_data_o, 32'hA0000001);
    chk("ld44_req", mem_req_o, 0);
    $display("load 0x44 data=%h", cpu_data_o);

    // Write hit, then read it back
    cpu_we_i = 1'b1; cpu_addr_i = 32'h48; cpu_data_i = 32'h12345678;
    #1;
    chk("st48_stall", cpu_stall_o, 0);
    chk("st48_cdata", cpu_data_o, 0);
    tick();
    cpu_we_i = 1'b0;
    #1;
    chk("ld48_data", cpu_data_o, 32'h12345678);
    $display("store/load 0x48 data=%h", cpu_data_o);

    // Conflict miss on dirty line 2: write-back then refill
    exp_line = line_a;
    exp_line[95:64] = 32'h12345678;
    cpu_addr_i = 32'h248;
    miss("ld248", 1, 3, 32'h40, exp_line, 4, 32'h240, line_b);
    chk("ld248_data", cpu_data_o, 32'hB0000002);

    // Store miss to clean line, store merges afterwards in IDLE
    cpu_we_i = 1'b1; cpu_addr_i = 32'h100; cpu_data_i = 32'hCAFEF00D;
    miss("st100", 0, 0, 0, 0, 2, 32'h100, line_c);
    chk("st100_cdata", cpu_data_o, 0);
    tick();
    cpu_we_i = 1'b0;
    #1;
    chk("ld100_data", cpu_data_o, 32'hCAFEF00D);
    $display("store/load 0x100 data=%h", cpu_data_o);

    // Conflicting load at 0x300 writes back the merged line, 1-cycle memory
    exp_line = line_c;
    exp_line[31:0] = 32'hCAFEF00D;
    cpu_addr_i = 32'h300;
    miss("ld300", 1, 1, 32'h100, exp_line, 1, 32'h300, line_d);
    chk("ld300_data", cpu_data_o, 32'hD0000000);

    // Reset during REFILL aborts; stray ack ignored; cache is empty after
    cpu_addr_i = 32'h400;
    #1;
    chk("ld400_stall", cpu_stall_o, 1);
    tick();
    tick();
    chk("ld400_refill", {mem_req_o, mem_we_o, mem_addr_o}, {2'b10, 32'h400});
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    cpu_req_i = 1'b0;
    #1;
    chk("abort_req", mem_req_o, 0);
    chk("abort_stall", cpu_stall_o, 0);
    mem_ack_i = 1'b1;
    mem_data_i = line_d;
    tick();
    mem_ack_i = 1'b0;
    mem_data_i = '0;
    #1;
    chk("stray_req", mem_req_o, 0);
    chk("stray_stall", cpu_stall_o, 0);
    cpu_req_i = 1'b1;
    cpu_addr_i = 32'h44;
    #1;
    chk("post_rst_miss44", cpu_stall_o, 1);
    chk("post_rst_cdata", cpu_data_o, 0);
    cpu_addr_i = 32'h300;
    #1;
    chk("post_rst_miss300", cpu_stall_o, 1);
    $display("reset abort checked");
    cpu_req_i = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
